// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: shared widths, CSR addresses, mcause values and FSM states for the trap sequencer.
// TRAP_VECTORED_EN (see trap_ctrl) selects vectored interrupt targets.
package trap_ctrl_pkg;
   localparam int RegBus     = 32;
   localparam int CsrAddrBus = 12;

   localparam logic [CsrAddrBus-1:0] CSR_MSTATUS = 12'h300;
   localparam logic [CsrAddrBus-1:0] CSR_MTVEC   = 12'h305;
   localparam logic [CsrAddrBus-1:0] CSR_MEPC    = 12'h341;
   localparam logic [CsrAddrBus-1:0] CSR_MCAUSE  = 12'h342;
   localparam logic [CsrAddrBus-1:0] CSR_MTVAL   = 12'h343;

   localparam logic [RegBus-1:0] CAUSE_ILLEGAL = 32'h0000_0002;
   localparam logic [RegBus-1:0] CAUSE_EBREAK  = 32'h0000_0003;
   localparam logic [RegBus-1:0] CAUSE_ECALL   = 32'h0000_000B;
   localparam logic [RegBus-1:0] CAUSE_MEI     = 32'h8000_000B;
   localparam logic [RegBus-1:0] CAUSE_MSI     = 32'h8000_0003;
   localparam logic [RegBus-1:0] CAUSE_MTI     = 32'h8000_0007;

   typedef enum logic [2:0] {
      IDLE, E_MEPC, E_CAUSE, E_TVAL, E_MSTAT, E_JUMP, R_MSTAT, R_JUMP
   } state_e;

   // mstatus image carrying only MIE (bit 3) and MPIE (bit 7)
   function automatic logic [RegBus-1:0] mstatus_val(input logic mie, input logic mpie);
      return {24'h0, mpie, 3'b0, mie, 3'b0};
   endfunction
endpackage

// File: rtl/trap_ctrl_prio.sv
// trap_prio: picks the winning trap or mret request for the execute instruction.
module trap_prio
   import trap_ctrl_pkg::*;
(
   input  logic              inst_valid_i,
   input  logic              illegal_i,
   input  logic              ebreak_i,
   input  logic              ecall_i,
   input  logic              ex_trap_i,
   input  logic              soft_trap_i,
   input  logic              tcmp_trap_i,
   input  logic              mstatus_mie_i,
   input  logic              mret_i,
   input  logic [RegBus-1:0] inst_i,
   output logic              take_o,
   output logic              is_mret_o,
   output logic [RegBus-1:0] cause_o,
   output logic [RegBus-1:0] tval_o
);
   logic exc, irq;

   assign exc       = illegal_i || ebreak_i || ecall_i;
   assign irq       = mstatus_mie_i && (ex_trap_i || soft_trap_i || tcmp_trap_i);
   assign take_o    = inst_valid_i && (exc || irq || mret_i);
   // an interrupt beats mret; the mret re-executes after the handler returns
   assign is_mret_o = inst_valid_i && mret_i && !exc && !irq;
   assign cause_o   = illegal_i ? CAUSE_ILLEGAL :
                      ebreak_i  ? CAUSE_EBREAK  :
                      ecall_i   ? CAUSE_ECALL   :
                      !irq      ? '0            :
                      ex_trap_i ? CAUSE_MEI     :
                      soft_trap_i ? CAUSE_MSI   : CAUSE_MTI;
   assign tval_o    = illegal_i ? inst_i : '0;
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: sequences CSR updates for trap entry and mret, then redirects the PC.
// Define TRAP_VECTORED_EN for vectored interrupt targets when mtvec[0] is set.
module trap_ctrl
   import trap_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ex_trap_i,
   input  logic                  tcmp_trap_i,
   input  logic                  soft_trap_i,
   input  logic                  mstatus_mie_i,
   input  logic                  inst_valid_i,
   input  logic [RegBus-1:0]     inst_pc_i,
   input  logic [RegBus-1:0]     inst_i,
   input  logic                  ecall_i,
   input  logic                  ebreak_i,
   input  logic                  illegal_i,
   input  logic                  mret_i,
   input  logic                  idex_csr_we_i,
   input  logic [RegBus-1:0]     mepc_i,
   output logic                  trap_csr_we_o,
   output logic [CsrAddrBus-1:0] trap_csr_addr_o,
   output logic [RegBus-1:0]     trap_csr_wdata_o,
   input  logic [RegBus-1:0]     trap_csr_rdata_i,
   output logic                  hold_o,
   output logic                  kill_o,
   output logic                  jump_o,
   output logic [RegBus-1:0]     jump_addr_o
);
   state_e            state_q, state_d;
   logic [RegBus-1:0] cause_q, cause_d, pc_q, pc_d, tval_q, tval_d;
   logic [RegBus-1:0] p_cause, p_tval, base, target;
   logic              take, is_mret, accept;

   trap_prio u_prio (
      .inst_valid_i  (inst_valid_i),
      .illegal_i     (illegal_i),
      .ebreak_i      (ebreak_i),
      .ecall_i       (ecall_i),
      .ex_trap_i     (ex_trap_i),
      .soft_trap_i   (soft_trap_i),
      .tcmp_trap_i   (tcmp_trap_i),
      .mstatus_mie_i (mstatus_mie_i),
      .mret_i        (mret_i),
      .inst_i        (inst_i),
      .take_o        (take),
      .is_mret_o     (is_mret),
      .cause_o       (p_cause),
      .tval_o        (p_tval)
   );

   // gated by rst_n so every output is 0 while reset is held
   assign accept = rst_n && state_q == IDLE && take;
   assign base   = trap_csr_rdata_i & ~32'h3;
`ifdef TRAP_VECTORED_EN
   assign target = (trap_csr_rdata_i[0] && cause_q[31]) ? base + {cause_q[29:0], 2'b00} : base;
`else
   assign target = base;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cause_q <= '0;
         pc_q    <= '0;
         tval_q  <= '0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         pc_q    <= pc_d;
         tval_q  <= tval_d;
      end
   end

   always_comb begin
      cause_d = accept ? p_cause : cause_q;
      pc_d    = accept ? inst_pc_i : pc_q;
      tval_d  = accept ? p_tval : tval_q;
      state_d = state_q;
      // a write state only advances when the execute stage left the CSR port free
      case (state_q)
         IDLE:    state_d = !accept ? IDLE : is_mret ? R_MSTAT : E_MEPC;
         E_MEPC:  state_d = idex_csr_we_i ? E_MEPC : E_CAUSE;
         E_CAUSE: state_d = idex_csr_we_i ? E_CAUSE : E_TVAL;
         E_TVAL:  state_d = idex_csr_we_i ? E_TVAL : E_MSTAT;
         E_MSTAT: state_d = idex_csr_we_i ? E_MSTAT : E_JUMP;
         R_MSTAT: state_d = idex_csr_we_i ? R_MSTAT : R_JUMP;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      hold_o           = accept || state_q != IDLE;
      kill_o           = accept;
      jump_o           = 1'b0;
      jump_addr_o      = '0;
      trap_csr_we_o    = 1'b0;
      trap_csr_addr_o  = '0;
      trap_csr_wdata_o = '0;
      case (state_q)
         E_MEPC: begin
            trap_csr_we_o    = 1'b1;
            trap_csr_addr_o  = CSR_MEPC;
            trap_csr_wdata_o = pc_q;
         end
         E_CAUSE: begin
            trap_csr_we_o    = 1'b1;
            trap_csr_addr_o  = CSR_MCAUSE;
            trap_csr_wdata_o = cause_q;
         end
         E_TVAL: begin
            trap_csr_we_o    = 1'b1;
            trap_csr_addr_o  = CSR_MTVAL;
            trap_csr_wdata_o = tval_q;
         end
         E_MSTAT: begin
            trap_csr_we_o    = 1'b1;
            trap_csr_addr_o  = CSR_MSTATUS;
            trap_csr_wdata_o = mstatus_val(1'b0, trap_csr_rdata_i[3]);
         end
         E_JUMP: begin
            trap_csr_addr_o  = CSR_MTVEC;
            jump_o           = 1'b1;
            jump_addr_o      = target;
         end
         R_MSTAT: begin
            trap_csr_we_o    = 1'b1;
            trap_csr_addr_o  = CSR_MSTATUS;
            trap_csr_wdata_o = mstatus_val(trap_csr_rdata_i[7], 1'b1);
         end
         R_JUMP: begin
            jump_o           = 1'b1;
            jump_addr_o      = mepc_i;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed and randomized checks of trap_ctrl against a CSR file model
// and a priority-table reference for trap selection, latency and CSR results.
module tb_trap_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_trap_i, tcmp_trap_i, soft_trap_i, mstatus_mie_i, inst_valid_i;
   logic        ecall_i, ebreak_i, illegal_i, mret_i, idex_csr_we_i;
   logic [31:0] inst_pc_i, inst_i, mepc_i, trap_csr_wdata_o, trap_csr_rdata_i, jump_addr_o;
   logic [11:0] trap_csr_addr_o;
   logic        trap_csr_we_o, hold_o, kill_o, jump_o;
   logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause, m_mtval;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   assign mepc_i = m_mepc;

   always_comb begin
      trap_csr_rdata_i = 32'h0;
      case (trap_csr_addr_o)
         12'h300: trap_csr_rdata_i = m_mstatus;
         12'h305: trap_csr_rdata_i = m_mtvec;
         12'h341: trap_csr_rdata_i = m_mepc;
         12'h342: trap_csr_rdata_i = m_mcause;
         12'h343: trap_csr_rdata_i = m_mtval;
         default: trap_csr_rdata_i = 32'h0;
      endcase
   end

   trap_ctrl dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .ex_trap_i        (ex_trap_i),
      .tcmp_trap_i      (tcmp_trap_i),
      .soft_trap_i      (soft_trap_i),
      .mstatus_mie_i    (mstatus_mie_i),
      .inst_valid_i     (inst_valid_i),
      .inst_pc_i        (inst_pc_i),
      .inst_i           (inst_i),
      .ecall_i          (ecall_i),
      .ebreak_i         (ebreak_i),
      .illegal_i        (illegal_i),
      .mret_i           (mret_i),
      .idex_csr_we_i    (idex_csr_we_i),
      .mepc_i           (mepc_i),
      .trap_csr_we_o    (trap_csr_we_o),
      .trap_csr_addr_o  (trap_csr_addr_o),
      .trap_csr_wdata_o (trap_csr_wdata_o),
      .trap_csr_rdata_i (trap_csr_rdata_i),
      .hold_o           (hold_o),
      .kill_o           (kill_o),
      .jump_o           (jump_o),
      .jump_addr_o      (jump_addr_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "/hold"}, hold_o, 0);
      chk({tag, "/kill"}, kill_o, 0);
      chk({tag, "/jump"}, jump_o, 0);
      chk({tag, "/jaddr"}, jump_addr_o, 0);
      chk({tag, "/we"}, trap_csr_we_o, 0);
      chk({tag, "/addr"}, trap_csr_addr_o, 0);
      chk({tag, "/wdata"}, trap_csr_wdata_o, 0);
   endtask

   // CSR file model: a trap write lands unless the execute stage owns the port
   task automatic tick();
      logic        w;
      logic [11:0] a;
      logic [31:0] d;
      w = trap_csr_we_o && !idex_csr_we_i;
      a = trap_csr_addr_o;
      d = trap_csr_wdata_o;
      @(posedge clk);
      if (w)
         case (a)
            12'h300: m_mstatus = d;
            12'h305: m_mtvec   = d;
            12'h341: m_mepc    = d;
            12'h342: m_mcause  = d;
            12'h343: m_mtval   = d;
            default: ;
         endcase
      @(negedge clk);
   endtask

   // r: [0]illegal [1]ebreak [2]ecall [3]ext [4]soft [5]timer [6]mret
   task automatic drive(input logic [6:0] r, input logic mie, input logic [31:0] pc, input logic [31:0] inst);
      {mret_i, tcmp_trap_i, soft_trap_i, ex_trap_i, ecall_i, ebreak_i, illegal_i} = r;
      mstatus_mie_i = mie;
      inst_pc_i     = pc;
      inst_i        = inst;
      inst_valid_i  = 1'b1;
      idex_csr_we_i = 1'b0;
   endtask

   task automatic drive_idle();
      drive(7'h0, 1'b0, 32'h0, 32'h0);
      inst_valid_i = 1'b0;
   endtask

   // reference: first matching entry of the priority table wins, mret last
   task automatic ref_req(input logic [6:0] r, input logic mie, input logic [31:0] inst,
                          output logic take, output logic ret, output logic [31:0] cause, output logic [31:0] tval);
      logic [31:0] causes [6];
      causes = '{32'd2, 32'd3, 32'd11, 32'h8000000B, 32'h80000003, 32'h80000007};
      take = 0; ret = 0; cause = 0; tval = 0;
      for (int i = 0; i < 6; i++)
         if (!take && r[i] && (i < 3 || mie)) begin
            take  = 1;
            cause = causes[i];
            tval  = (i == 0) ? inst : 32'h0;
         end
      if (!take && r[6]) begin
         take = 1;
         ret  = 1;
      end
   endtask

   task automatic run(input string tag, input logic [6:0] r, input logic mie, input logic [31:0] pc,
                      input logic [31:0] inst, input logic [3:0] coll, input logic rnd);
      logic        take, ret;
      logic [31:0] cause, tval, old_ms, base;
      int          need, done;
      logic [3:0]  stalled;
      ref_req(r, mie, inst, take, ret, cause, tval);
      drive(r, mie, pc, inst);
      #1;
      chk({tag, "/acc_hold"}, hold_o, take);
      chk({tag, "/acc_kill"}, kill_o, take);
      chk({tag, "/acc_jump"}, jump_o, 0);
      chk({tag, "/acc_we"}, trap_csr_we_o, 0);
      old_ms = m_mstatus;
      tick();
      if (!take) return;
      base = m_mtvec & ~32'h3;
`ifdef TRAP_VECTORED_EN
      if (m_mtvec[0] && cause[31]) base = base + 4 * (cause & 32'h7FFF_FFFF);
`endif
      need    = ret ? 1 : 4;
      done    = 0;
      stalled = '0;
      for (int k = 0; k < 16; k++) begin
         {mret_i, tcmp_trap_i, soft_trap_i, ex_trap_i, ecall_i, ebreak_i, illegal_i} = 7'($urandom);
         inst_valid_i  = 1'($urandom);
         mstatus_mie_i = 1'($urandom);
         idex_csr_we_i = 1'b0;
         if (done < need) begin
            idex_csr_we_i = (coll[done] && !stalled[done]) || (rnd && $urandom_range(0, 3) == 0);
            if (coll[done]) stalled[done] = 1'b1;
         end
         #1;
         chk({tag, "/seq_hold"}, hold_o, 1);
         chk({tag, "/seq_jump"}, jump_o, 32'(done == need));
         if (done == need) begin
            chk({tag, "/jaddr"}, jump_addr_o, ret ? m_mepc : base);
            break;
         end
         if (!idex_csr_we_i) done++;
         tick();
      end
      tick();
      drive_idle();
      #1;
      chk({tag, "/post_hold"}, hold_o, 0);
      if (ret)
         chk({tag, "/mstatus"}, m_mstatus, {24'h0, 1'b1, 3'h0, old_ms[7], 3'h0});
      else begin
         chk({tag, "/mepc"}, m_mepc, pc);
         chk({tag, "/mcause"}, m_mcause, cause);
         chk({tag, "/mtval"}, m_mtval, tval);
         chk({tag, "/mstatus"}, m_mstatus, {24'h0, old_ms[3], 7'h0});
      end
      tick();
   endtask

   initial begin
      m_mstatus = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
      rst_n = 1'b0;
      drive(7'h01, 1'b1, 32'h80, 32'h1234);
      #1;
      chk_zero("reset");
      @(negedge clk);
      @(negedge clk);
      drive_idle();
      m_mtvec   = 32'hD0;
      m_mstatus = 32'h08;
      rst_n     = 1'b1;
      #1;
      chk_zero("idle");
      @(negedge clk);

      run("illegal", 7'h01, 1'b0, 32'h100, 32'hFFFF_FFFF, 4'b0, 1'b0);
      m_mstatus = 32'h08;
      run("ext_irq", 7'h08, 1'b1, 32'h200, 32'h13, 4'b0, 1'b0);
      run("gated", 7'h30, 1'b0, 32'h300, 32'h13, 4'b0, 1'b0);
      run("soft_first", 7'h30, 1'b1, 32'h304, 32'h13, 4'b0, 1'b0);
      run("coll_cause", 7'h04, 1'b0, 32'h310, 32'h73, 4'b0010, 1'b0);
      m_mepc    = 32'h344;
      m_mstatus = 32'h80;
      run("mret", 7'h40, 1'b0, 32'h500, 32'h30200073, 4'b0, 1'b0);
      run("irq_mret", 7'h60, 1'b1, 32'h600, 32'h30200073, 4'b0, 1'b0);
      m_mtvec = 32'h101;
      run("vec_tmr", 7'h20, 1'b1, 32'h700, 32'h13, 4'b0, 1'b0);
      run("vec_exc", 7'h02, 1'b1, 32'h704, 32'h100073, 4'b0, 1'b0);

      // asynchronous reset while writing mtval
      drive(7'h01, 1'b0, 32'h400, 32'hDEAD);
      tick();
      tick();
      tick();
      #1;
      chk("rst_seq/addr_tval", trap_csr_addr_o, 32'h343);
      rst_n = 1'b0;
      #1;
      chk_zero("rst_seq");
      chk("rst_seq/partial_mepc", m_mepc, 32'h400);
      drive_idle();
      @(negedge clk);
      rst_n = 1'b1;
      run("post_rst", 7'h04, 1'b0, 32'h410, 32'h73, 4'b0, 1'b0);

      for (int n = 0; n < 300; n++) begin
         logic [6:0] r;
         for (int b = 0; b < 7; b++) r[b] = ($urandom_range(0, 3) == 0);
         m_mtvec   = $urandom;
         m_mstatus = $urandom;
         m_mepc    = $urandom;
         run("rand", r, 1'($urandom), $urandom & ~32'h3, $urandom, 4'b0, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
